// File: rtl/rt_mem_boot_ctrl.sv
// Boot sequencer that streams a firmware image into dp_ram port B, then hands port B to the core.
// Optional image checksum gate: define RT_BOOT_CHECKSUM_EN.
module rt_mem_boot_ctrl #(
  parameter int ADDR_WIDTH   = 22,
  parameter int FUNCT_WIDTH  = 3,
  parameter int NUM_WORDS    = 4153,
  parameter int BASE_ADDR    = 0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   load_valid_i,
  input  logic [31:0]            load_data_i,
  output logic                   load_ready_o,
  input  logic                   core_en_i,
  input  logic                   core_we_i,
  input  logic [ADDR_WIDTH-1:0]  core_addr_i,
  input  logic [31:0]            core_wdata_i,
  input  logic [3:0]             core_be_i,
  input  logic [FUNCT_WIDTH-1:0] core_funct_i,
  input  logic                   core_we_funct_i,
  input  logic [ADDR_WIDTH-1:0]  core_range_i,
  output logic                   core_gnt_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_be_o,
  output logic [FUNCT_WIDTH-1:0] mem_funct_o,
  output logic                   mem_we_funct_o,
  output logic [ADDR_WIDTH-1:0]  mem_range_o,
  output logic                   busy_o,
  output logic                   fetch_enable_o,
  output logic [31:0]            words_o,
`ifdef RT_BOOT_CHECKSUM_EN
  input  logic [31:0]            exp_sum_i,
  output logic [31:0]            sum_o,
  output logic                   sum_err_o,
`endif
  output logic [1:0]             state_o
);

  // Image stream handshake: a word is accepted in any cycle where load_valid_i
  // and load_ready_o are both high; load_ready_o is high exactly in LOAD.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0]           LAST_IDX   = (NUM_WORDS > 0) ? 32'(NUM_WORDS - 1) : 32'd0;
  localparam logic [31:0]           WORDS_MAX  = 32'(NUM_WORDS);
  localparam logic [31:0]           DRAIN_LAST = 32'(DRAIN_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);

  state_t                 state_q, state_d;
  logic [31:0]            words_q;
  logic [31:0]            drain_q;
  logic                   en_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [31:0]            wdata_q;
  logic                   hs, last_hs, drain_end, sum_ok;
  logic [ADDR_WIDTH-1:0]  word_off;

  assign hs        = (state_q == LOAD) && load_valid_i;
  assign last_hs   = hs && (words_q == LAST_IDX);
  assign drain_end = (state_q == DRAIN) && (drain_q == DRAIN_LAST);
  assign word_off  = ADDR_WIDTH'(words_q) << 2;
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (NUM_WORDS == 0) ? DRAIN : LOAD;
      LOAD:    if (last_hs) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  // The drain counter starts at 0 in the cycle of the final pulse, so the
  // pulse itself is not one of the counted idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      drain_q <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      en_q    <= hs;
      addr_q  <= hs ? (BASE + word_off) : '0;
      wdata_q <= hs ? load_data_i : '0;
      if (hs && (words_q != WORDS_MAX)) words_q <= words_q + 32'd1;
      if ((state_q == DRAIN) && !drain_end) drain_q <= drain_q + 32'd1;
      else if (state_q != DRAIN)            drain_q <= '0;
    end
  end

`ifdef RT_BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        sum_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      if (hs)        sum_q     <= sum_q ^ load_data_i;
      if (drain_end) sum_err_q <= (sum_q != exp_sum_i);
    end
  end
  assign sum_o     = sum_q;
  assign sum_err_o = sum_err_q;
  assign sum_ok    = !sum_err_q;
`else
  assign sum_ok    = 1'b1;
`endif

  always_comb begin
    load_ready_o   = (state_q == LOAD);
    busy_o         = (state_q == LOAD) || (state_q == DRAIN);
    core_gnt_o     = (state_q == DONE);
    fetch_enable_o = (state_q == DONE) && sum_ok;
    words_o        = words_q;
    if (state_q == DONE) begin
      mem_en_o       = core_en_i;
      mem_we_o       = core_we_i;
      mem_addr_o     = core_addr_i;
      mem_wdata_o    = core_wdata_i;
      mem_be_o       = core_be_i;
      mem_funct_o    = core_funct_i;
      mem_we_funct_o = core_we_funct_i;
      mem_range_o    = core_range_i;
    end else begin
      mem_en_o       = en_q;
      mem_we_o       = en_q;
      mem_addr_o     = addr_q;
      mem_wdata_o    = wdata_q;
      mem_be_o       = {4{en_q}};
      mem_funct_o    = '0;
      mem_we_funct_o = 1'b0;
      mem_range_o    = '0;
    end
  end

endmodule

// File: tb/tb_rt_mem_boot_ctrl.sv
// Bench for rt_mem_boot_ctrl: randomized image loads checked against an address/timing model.
// Exercises the RT_BOOT_CHECKSUM_EN ports when that macro is defined.
module tb_rt_mem_boot_ctrl;
  localparam int AW   = 6;
  localparam int FW   = 3;
  localparam int NW   = 6;
  localparam int BASE = 52;  // 0x34: words 3..5 wrap past 2^AW
  localparam int DC   = 3;
  localparam int EW   = AW + 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, load_valid_i = 1'b0;
  logic [31:0]   load_data_i = '0;
  logic          load_ready_o;
  logic          core_en_i = 1'b0, core_we_i = 1'b0, core_we_funct_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0, core_range_i = '0;
  logic [31:0]   core_wdata_i = '0;
  logic [3:0]    core_be_i = '0;
  logic [FW-1:0] core_funct_i = '0;
  logic          core_gnt_o, mem_en_o, mem_we_o, mem_we_funct_o, busy_o, fetch_enable_o;
  logic [AW-1:0] mem_addr_o, mem_range_o;
  logic [31:0]   mem_wdata_o, words_o;
  logic [3:0]    mem_be_o;
  logic [FW-1:0] mem_funct_o;
  logic [1:0]    state_o;
`ifdef RT_BOOT_CHECKSUM_EN
  logic [31:0]   exp_sum_i = '0;
  logic [31:0]   sum_o;
  logic          sum_err_o;
`endif

  rt_mem_boot_ctrl #(.ADDR_WIDTH(AW), .FUNCT_WIDTH(FW), .NUM_WORDS(NW),
                     .BASE_ADDR(BASE), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .core_en_i(core_en_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_funct_i(core_funct_i),
    .core_we_funct_i(core_we_funct_i), .core_range_i(core_range_i), .core_gnt_o(core_gnt_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_funct_o(mem_funct_o),
    .mem_we_funct_o(mem_we_funct_o), .mem_range_o(mem_range_o),
    .busy_o(busy_o), .fetch_enable_o(fetch_enable_o), .words_o(words_o),
`ifdef RT_BOOT_CHECKSUM_EN
    .exp_sum_i(exp_sum_i), .sum_o(sum_o), .sum_err_o(sum_err_o),
`endif
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: expected {addr, data} of each write pulse, in order
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_bus();
    return 128'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
                 mem_funct_o, mem_we_funct_o, mem_range_o});
  endfunction

  function automatic logic [127:0] core_bus();
    return 128'({core_en_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
                 core_funct_i, core_we_funct_i, core_range_i});
  endfunction

  function automatic logic [127:0] pulse_bus(input logic [AW-1:0] a, input logic [31:0] d);
    return 128'({1'b1, 1'b1, a, d, 4'hF, {FW{1'b0}}, 1'b0, {AW{1'b0}}});
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_core(input bit lim_funct);
    core_en_i       = 1'($urandom_range(0, 1));
    core_we_i       = 1'($urandom_range(0, 1));
    core_addr_i     = AW'($urandom());
    core_wdata_i    = $urandom();
    core_be_i       = 4'($urandom());
    core_funct_i    = lim_funct ? 3'b101 : FW'($urandom());
    core_we_funct_i = 1'($urandom_range(0, 1));
    core_range_i    = AW'($urandom());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {load_ready_o, busy_o, core_gnt_o, fetch_enable_o, state_o, words_o}, 0);
    check({tag, "_mem"}, mem_bus(), 0);
`ifdef RT_BOOT_CHECKSUM_EN
    check({tag, "_sum"}, {sum_o, sum_err_o}, 0);
`endif
  endtask

  task automatic check_pulse(input bit p);
    logic [EW-1:0] e;
    if (p) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("write_pulse", mem_bus(), pulse_bus(e[EW-1:32], e[31:0]));
    end else begin
      check("no_pulse", mem_bus(), 0);
    end
  endtask

  // mode 0: continuous valid, 1: bubble between words, 2: random valid
  task automatic run_load(input int mode, input bit bad_sum);
    int          acc = 0;
    int          iter = 0;
    bit          prev_hs = 1'b0;
    bit          v;
    logic [31:0] d;
    logic [31:0] sum = '0;
    check("idle_ready", {load_ready_o, busy_o, core_gnt_o}, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (acc < NW) begin
      check_pulse(prev_hs);
      check("load_ctl", {load_ready_o, busy_o, core_gnt_o, fetch_enable_o}, 4'b1100);
      check("load_words", words_o, acc);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (iter % 2 == 0);
      else                v = (iter > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      d = $urandom();
      load_valid_i = v;
      load_data_i  = d;
      rand_core(1'b1);
      if (v) begin
        exp_q.push_back({AW'((BASE + 4 * acc) % (1 << AW)), d});
        sum ^= d;
        acc++;
      end
      prev_hs = v;
      iter++;
      tick();
    end
    // Valid left high after the last word must not be accepted
    load_valid_i = 1'b1;
    load_data_i  = $urandom();
    check_pulse(1'b1);
    check("last_ctl", {load_ready_o, busy_o, core_gnt_o}, 3'b010);
    check("last_words", words_o, NW);
`ifdef RT_BOOT_CHECKSUM_EN
    exp_sum_i = bad_sum ? ~sum : sum;
`endif
    for (int i = 0; i < DC; i++) begin
      tick();
      rand_core(1'b1);
      check_pulse(1'b0);
      check("drain_ctl", {load_ready_o, busy_o, core_gnt_o, fetch_enable_o}, 4'b0100);
    end
    tick();
    load_valid_i = 1'b0;
    check("done_ctl", {load_ready_o, busy_o, core_gnt_o}, 3'b001);
`ifdef RT_BOOT_CHECKSUM_EN
    check("done_fetch", fetch_enable_o, !bad_sum);
    check("done_sum", {sum_o, sum_err_o}, {sum, bad_sum});
`else
    check("done_fetch", fetch_enable_o, 1'b1);
`endif
    check("done_words", words_o, NW);
    check("scoreboard_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      start_i = 1'b1;
      rand_core(1'b0);
      #1;
      check("passthru", mem_bus(), core_bus());
      tick();
      check("done_sticky", {core_gnt_o, busy_o}, 2'b10);
    end
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_core(1'b0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    run_load(0, 1'b0);

    do_reset();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    load_valid_i = 1'b1;
    load_data_i  = $urandom();
    tick();
    load_data_i  = $urandom();
    tick();
    check("partial_words", words_o, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    load_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    run_load(1, 1'b0);

    do_reset();
    run_load(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rt_mem_boot_ctrl.md
# rt_mem_boot_ctrl

Synthesizable boot sequencer and port-B owner for the racetrack LiM data memory. After reset it streams a firmware image, one 32-bit word per cycle, into port B at sequential byte addresses, masking all LiM function controls during the load. It then drains for a fixed number of cycles, hands port B to the core's data side, and asserts `fetch_enable_o`. This replaces simulation-only port forcing with a real controller between the boot source, the core, and `dp_ram`.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: port-B byte address width.
- `FUNCT_WIDTH`, 3: LiM function code width.
- `NUM_WORDS`, 4153: number of words in the image.
- `BASE_ADDR`, 0: byte address of the first word.
- `DRAIN_CYCLES`, 3: idle cycles between the last write pulse and handover. Must be at least 1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: begin the load. Sampled only in IDLE.
- `load_valid_i` in 1, `load_data_i` in 32, `load_ready_o` out 1: image word stream (valid/ready).
- `core_en_i`, `core_we_i` in 1; `core_addr_i` in ADDR_WIDTH; `core_wdata_i` in 32; `core_be_i` in 4; `core_funct_i` in FUNCT_WIDTH; `core_we_funct_i` in 1; `core_range_i` in ADDR_WIDTH: core port-B request.
- `core_gnt_o` out 1: core owns port B.
- `mem_en_o`, `mem_we_o` out 1; `mem_addr_o` out ADDR_WIDTH; `mem_wdata_o` out 32; `mem_be_o` out 4; `mem_funct_o` out FUNCT_WIDTH; `mem_we_funct_o` out 1; `mem_range_o` out ADDR_WIDTH: to `dp_ram` port B.
- `busy_o` out 1: the controller is in LOAD or DRAIN.
- `fetch_enable_o` out 1: core fetch enable. Sticky once set.
- `words_o` out 32: number of words written so far.

## Operation
States:
- IDLE: waits for `start_i`.
- LOAD: writes image words.
- DRAIN: counts idle cycles.
- DONE: port B belongs to the core.

Transitions:
- IDLE → LOAD on `start_i`.
- IDLE → DRAIN on `start_i` when `NUM_WORDS`=0.
- LOAD → DRAIN on the handshake of word `NUM_WORDS-1`.
- DRAIN → DONE after `DRAIN_CYCLES` cycles.
- DONE is terminal until reset. `start_i` is ignored outside IDLE.

LOAD behaviour:
- `load_ready_o` = 1 in every LOAD cycle. It is 0 in all other states.
- Each handshake writes word k to byte address `(BASE_ADDR + 4*k) mod 2^ADDR_WIDTH`. Addresses wrap silently.
- During a write pulse: `mem_we_o`=1, `mem_be_o`=4'hF, `mem_funct_o`=0, `mem_we_funct_o`=0, `mem_range_o`=0.
- Cycles with no handshake produce `mem_en_o`=0.

Port-B ownership:
- IDLE, LOAD, DRAIN: `mem_*` is driven by the controller. Outside a pulse all `mem_*` outputs are 0, and all `core_*` inputs are ignored. `core_gnt_o`=0.
- DONE: every `mem_*` output is a combinational pass-through of the matching `core_*` input. `core_gnt_o`=1 and `fetch_enable_o`=1.

`words_o` increments on each handshake and saturates at `NUM_WORDS`.

## Timing
- Controller `mem_*` outputs are registered. A handshake in cycle t produces `mem_en_o`=1 with that word's address and data in cycle t+1, for exactly one cycle.
- Back-to-back handshakes give one write per cycle.
- DRAIN counts `DRAIN_CYCLES` cycles after the last write pulse, not counting that pulse. `fetch_enable_o` and `core_gnt_o` rise on the following edge.
- Example: `NUM_WORDS`=N, `DRAIN_CYCLES`=3, with `start_i` in cycle 0 and `load_valid_i` held high. The last pulse occurs in cycle N+1, and `fetch_enable_o` rises in cycle N+5.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-LOAD or mid-DRAIN aborts the load immediately. Outputs return to their reset values asynchronously, and any partially written image is not resumed.

## Configuration
- `RT_BOOT_CHECKSUM_EN` defined:
  - Adds input `exp_sum_i` (32) and outputs `sum_o` (32) and `sum_err_o` (1).
  - `sum_o` is the running XOR of all accepted words, reset to 0.
  - On entry to DONE, `sum_err_o` is set to `(sum_o != exp_sum_i)` and held until reset.
  - When `sum_err_o`=1, the controller still enters DONE, but `fetch_enable_o` stays 0.
- `RT_BOOT_CHECKSUM_EN` undefined: these ports and the checksum logic do not exist, and the handover is unconditional.

## Test plan
- `NUM_WORDS`=4, `BASE_ADDR`=0, continuous valid, data 0x11,0x22,0x33,0x44 → write pulses to addresses 0x0, 0x4, 0x8, 0xC with the matching data in cycles 2–5; `fetch_enable_o` rises in cycle 9; `words_o`=4.
- Valid gaps: 1-cycle bubble between every word → no `mem_en_o` in bubble cycles; addresses stay contiguous; drain timing counts from the last pulse.
- Core isolation: toggle `core_en_i`/`core_we_i` with `core_funct_i`=3'b101 during LOAD → `mem_funct_o`=0 and no core write appears; after DONE, `mem_addr_o` follows `core_addr_i` in the same cycle.
- Wrap: `ADDR_WIDTH`=4, `BASE_ADDR`=0xC, 2 words → addresses 0xC then 0x0.
- Reset mid-LOAD after 2 of 4 words → all outputs 0 asynchronously; a new `start_i` restarts at `BASE_ADDR` with `words_o`=0.
- With `RT_BOOT_CHECKSUM_EN`: image 0xA5A5A5A5, 0x0F0F0F0F with `exp_sum_i`=0xAAAAAAAA → `sum_err_o`=0 and `fetch_enable_o`=1; with `exp_sum_i`=0 → `sum_err_o`=1 and `fetch_enable_o`=0.
